// File: rtl/reg_file_dumper_pkg.sv
// Shared definitions for the register-file debug dumper.
//   state_t        : dumper FSM states (IDLE, LOAD, SEND, WAIT, DONE)
//   BYTE_W         : width of one serialized transfer (the UART byte)
//   BYTES_PER_WORD : bytes per register word at the default 32-bit width
//   bytes_per_word : same quantity for any register width
package reg_file_dumper_pkg;

  localparam int BYTE_W = 8;
  localparam int BYTES_PER_WORD = 32 / BYTE_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/reg_file_dumper_word_serializer.sv
// Word serializer: captures one register word and presents it a byte at a
// time, most significant byte first.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture load_data and restart at byte 0
//   shift      : advance to the next lower byte
//   load_data  : register word to capture
//   byte_out   : current byte (registered, top byte of the shift register)
//   last_byte  : the current byte is the least significant one of the word
module reg_file_dumper_word_serializer
  import reg_file_dumper_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic [7:0]       byte_out,
  output logic             last_byte
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load) begin
      shreg    <= load_data;
      byte_idx <= '0;
    end else if (shift) begin
      // Shifting left keeps the byte to send in the top lane, so byte_out
      // is always a plain register slice.
      shreg    <= shreg << BYTE_W;
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  assign byte_out  = shreg[WIDTH-1 -: BYTE_W];
  assign last_byte = (byte_idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/reg_file_dumper.sv
// Register-file dumper: on start, reads registers 0..NUM_REGISTERS-1 through
// the register file read port and sends each word MSB byte first as single
// byte transfers to the UART transmitter.
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle dump request, honoured only in IDLE
//   rd_addr    : register file read address (current register, 0 in IDLE)
//   rd_data    : combinational register file read data for rd_addr
//   tx_start   : one-cycle pulse, tx_data holds a new byte
//   tx_data    : byte to transmit, stable from one tx_start to the next
//   tx_done    : one-cycle pulse from the transmitter, previous byte sent
//   busy       : dump in progress (LOAD through DONE)
//   done       : one-cycle pulse after the final byte's tx_done
//
// Handshake: each byte is offered with a single tx_start pulse; the block
// then waits for exactly one tx_done before offering anything else. A
// tx_done arriving outside WAIT (including the SEND cycle itself) is
// dropped, so the transmitter must answer after the cycle of tx_start.
module reg_file_dumper
  import reg_file_dumper_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int WIDTH_ADD     = 5,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH_ADD-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 done
);

  // Explicit terminal value so the register loop never depends on the
  // index counter wrapping when NUM_REGISTERS < 2**WIDTH_ADD.
  localparam logic [WIDTH_ADD-1:0] LAST_REG = WIDTH_ADD'(NUM_REGISTERS - 1);

  state_t               state, state_next;
  logic [WIDTH_ADD-1:0] reg_idx;
  logic                 ser_load;
  logic                 ser_shift;
  logic                 reg_inc;
  logic                 last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    reg_inc    = 1'b0;
    tx_start   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        ser_load   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (!last_byte) begin
            ser_shift  = 1'b1;
            state_next = SEND;
          end else if (reg_idx < LAST_REG) begin
            reg_inc    = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Cleared on leaving DONE as well as on start so rd_addr reads 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_idx <= '0;
    end else if ((state == DONE) || ((state == IDLE) && start)) begin
      reg_idx <= '0;
    end else if (reg_inc) begin
      reg_idx <= reg_idx + WIDTH_ADD'(1);
    end
  end

  assign rd_addr = reg_idx;

  // rd_data is captured at the edge ending LOAD; the register file writes
  // on the falling edge, so the read data is settled by then.
  reg_file_dumper_word_serializer #(
    .WIDTH(WIDTH)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (rd_data),
    .byte_out  (tx_data),
    .last_byte (last_byte)
  );

endmodule

// File: doc/reg_file_dumper.md
# reg_file_dumper

Debug read-out engine for the MIPS register file: on a start pulse it walks every register through a read port and serializes each word, MSB byte first, into single-byte transfers for the UART transmitter. It sits between the register file's read-address/read-data pair and the UART TX handshake (`tx_start`/`tx_done`) inside the debug unit. It is the reader counterpart to the write-back path that fills the register file.

## Interface
Parameters:
- `WIDTH`, 32, register width in bits; must be a multiple of 8.
- `WIDTH_ADD`, 5, register address width.
- `NUM_REGISTERS`, 32, registers to dump, addresses 0 to NUM_REGISTERS-1; must be ≤ 2^WIDTH_ADD.

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to dump all registers.
- `rd_addr`  out  WIDTH_ADD  register file read address.
- `rd_data`  in  WIDTH  register file combinational read data for `rd_addr`.
- `tx_start`  out  1  one-cycle pulse: `tx_data` is a new byte to send.
- `tx_data`  out  8  byte to transmit.
- `tx_done`  in  1  one-cycle pulse from UART TX: previous byte finished.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the last byte's `tx_done`.

## Operation
- Dump order:
  - Register 0 first, up to register NUM_REGISTERS-1.
  - Within a word, bytes go MSB first: bits [WIDTH-1:WIDTH-8] first.
  - BYTES_PER_WORD = WIDTH/8, so the total is NUM_REGISTERS*BYTES_PER_WORD bytes (128 at the defaults).
- FSM states are IDLE, LOAD, SEND, WAIT and DONE.
  - IDLE: `start`=1 → LOAD, with the register index cleared to 0 and the byte index cleared to 0.
  - LOAD: `rd_addr` = current index. At the end of the cycle, `rd_data` is captured into a WIDTH-bit shift register. → SEND.
  - SEND: `tx_start`=1 for exactly this cycle. `tx_data` = shift register [WIDTH-1:WIDTH-8]. → WAIT.
  - WAIT: holds until `tx_done`=1, then:
    - if the byte index < BYTES_PER_WORD-1: shift left by 8, increment the byte index, → SEND;
    - else if the register index < NUM_REGISTERS-1: increment the register index, clear the byte index, → LOAD;
    - else → DONE.
  - DONE: `done`=1 for one cycle. → IDLE.
- `tx_data` is registered and holds stable from SEND until the next SEND.
- `start` is ignored outside IDLE.
- `tx_done` is ignored outside WAIT.
  - This includes a `tx_done` in the same cycle as SEND: the block keeps waiting for the next `tx_done`.
- A register write into the register file while the dump is running is not guarded. The dump outputs whatever value is present in the LOAD cycle of that register.
- `rd_addr` is driven with the current register index in every state and is 0 in IDLE.

## Timing
- Reset (`reset`=1 at a rising edge):
  - state IDLE; `rd_addr`=0, `tx_start`=0, `tx_data`=0x00, `busy`=0, `done`=0.
  - Reset takes priority over every other input.
  - Reset mid-dump aborts immediately: no further `tx_start`, no `done`.
- Latency, with `start` sampled at edge k:
  - LOAD in cycle k+1;
  - `tx_start`=1 in cycle k+2;
  - WAIT from cycle k+3.
- After `tx_done` is sampled at edge m:
  - next byte of the same word: `tx_start` in cycle m+1;
  - first byte of the next word: LOAD in cycle m+1, `tx_start` in cycle m+2.
- After the final `tx_done` at edge m: `done`=1 in cycle m+1; `busy` drops and IDLE is reached in cycle m+2.
- A new `start` in that IDLE cycle is accepted.
- The register file writes on the falling edge. `rd_data` is therefore settled by the rising edge that ends LOAD, and no extra wait state is required.

## Structure
- Shared debug package holds:
  - the state enumeration (IDLE, LOAD, SEND, WAIT, DONE);
  - `BYTES_PER_WORD`;
  - the byte width constant 8.
- One sub-module is natural: `word_serializer`, which contains the WIDTH-bit load/shift register, the byte index and a `last_byte` flag.
  - The FSM, register index and handshake logic stay in `reg_file_dumper`.
- The register index counter is WIDTH_ADD bits. Its terminal compare is against NUM_REGISTERS-1 and must not rely on wrap-around.

## Test plan
- Reset, then idle: all outputs 0. `tx_done` pulses while in IDLE produce no `tx_start`.
- Reg1=0x12345678, all others 0. `start`, with a TX model returning `tx_done` 10 cycles after each `tx_start` → exactly 128 `tx_start` pulses; bytes 4..7 are 0x12, 0x34, 0x56, 0x78; `done` is pulsed once, one cycle after the 128th `tx_done`.
- Registers loaded with value = 0xA0A0A000+index; `tx_done` returned the cycle immediately after each `tx_start` → the byte stream matches in order; the first `tx_start` arrives 2 cycles after `start`.
- `start` pulsed during the dump, plus a `tx_done` injected in the same cycle as a SEND → the dump is not restarted and no byte is skipped; the total is still 128 bytes.
- `reset` asserted after byte 37's `tx_start` → the next cycle is IDLE with all outputs 0 and no `done`. A following `start` restarts from reg0, byte 0.
- NUM_REGISTERS=4, WIDTH=16 → 8 bytes in total, and `rd_addr` never exceeds 3.
